// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RV32I datapath.
// Holds FSM state encodings, opcodes, ALU op codes and the instruction layout.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_WORD = 3'b010;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    function automatic alu_op_t alu_funct(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// 32-bit combinational ALU for the multicycle datapath.
// Ports: op (operation), a/b (operands), y (result, modulo 2^32).
module mc_alu
    import multicycle_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << shamt;
            ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'b0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> shamt;
            ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I core: FSM, register file, immediate gen, unified mem port.
// Ports: clk, reset (async low), mem_* port, halted, retire, pc_dbg, state_dbg.
module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              retire,
    output logic [31:0]       pc_dbg,
    output logic [2:0]        state_dbg
);

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] alu_q;
    logic [31:0] rf [32];

    instr_t      ins;
    logic [31:0] imm;
    logic        f7_zero;
    logic        f7_alt;
    logic        is_op;
    logic        is_opimm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        legal;

    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] wb_data;

    assign ins = ir;

    assign f7_zero = ins.funct7 == 7'b0000000;
    assign f7_alt  = ins.funct7 == 7'b0100000;

    assign is_op = ins.opcode == OPC_OP
        && (f7_zero || (f7_alt
        && (ins.funct3 == 3'b000 || ins.funct3 == 3'b101)));

    assign is_opimm = ins.opcode == OPC_OP_IMM
        && ((ins.funct3 == 3'b001) ? f7_zero
        : (ins.funct3 == 3'b101) ? (f7_zero || f7_alt)
        : 1'b1);

    assign is_load   = ins.opcode == OPC_LOAD && ins.funct3 == F3_WORD;
    assign is_store  = ins.opcode == OPC_STORE && ins.funct3 == F3_WORD;
    assign is_branch = ins.opcode == OPC_BRANCH
        && ins.funct3 != 3'b010 && ins.funct3 != 3'b011;
    assign is_jal    = ins.opcode == OPC_JAL;
    assign is_jalr   = ins.opcode == OPC_JALR && ins.funct3 == 3'b000;
    assign is_lui    = ins.opcode == OPC_LUI;
    assign is_auipc  = ins.opcode == OPC_AUIPC;

    // SYSTEM (ECALL/EBREAK) is deliberately absent: it falls into HALT.
    assign legal = is_op | is_opimm | is_load | is_store | is_branch
        | is_jal | is_jalr | is_lui | is_auipc;

    always_comb begin
        imm = {{20{ir[31]}}, ir[31:20]};
        unique case (1'b1)
            is_store:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            is_branch:
                imm = {{19{ir[31]}}, ir[31], ir[7],
                       ir[30:25], ir[11:8], 1'b0};
            is_jal:
                imm = {{11{ir[31]}}, ir[31], ir[19:12],
                       ir[20], ir[30:21], 1'b0};
            is_lui || is_auipc:
                imm = {ir[31:12], 12'h000};
            default:
                imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        unique case (1'b1)
            is_op:
                alu_op = alu_funct(ins.funct3, ins.funct7[5]);
            is_opimm:
                alu_op = alu_funct(ins.funct3,
                    ins.funct7[5] && ins.funct3 == 3'b101);
            is_branch:
                alu_op = ins.funct3[2]
                    ? (ins.funct3[1] ? ALU_SLTU : ALU_SLT)
                    : ALU_SUB;
            is_lui:
                alu_op = ALU_PASS_B;
            default:
                alu_op = ALU_ADD;
        endcase
    end

    assign alu_a = is_auipc ? pc : rs1_q;
    assign alu_b = (is_op || is_branch) ? rs2_q : imm_q;

    mc_alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // funct3[0] inverts the base condition (BNE/BGE/BGEU).
    assign taken = (ins.funct3[2] ? alu_y[0] : (alu_y == 32'h0))
        ^ ins.funct3[0];

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc + imm_q;
    assign wb_data   = is_load ? mdr : alu_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   state_n = S_FETCH;
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    !legal:              state_n = S_HALT;
                    is_load || is_store: state_n = S_MEM;
                    is_branch:           state_n = S_FETCH;
                    default:             state_n = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_n = is_load ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_IDLE;
        endcase
    end

    assign mem_req   = state == S_FETCH || state == S_MEM;
    assign mem_we    = state == S_MEM && is_store;
    assign mem_addr  = (state == S_MEM)
        ? {alu_q[ADDR_W-1:2], 2'b00}
        : {pc[ADDR_W-1:2], 2'b00};
    assign mem_wdata = rs2_q;
    assign halted    = state == S_HALT;
    assign retire    = state == S_WB
        || (state == S_EXEC && is_branch)
        || (state == S_MEM && is_store && mem_ready);
    assign pc_dbg    = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= PC_RESET;
            ir    <= '0;
            mdr   <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            alu_q <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) ir <= mem_rdata;
                end
                S_DECODE: begin
                    rs1_q <= (ins.rs1 == 5'd0) ? '0 : rf[ins.rs1];
                    rs2_q <= (ins.rs2 == 5'd0) ? '0 : rf[ins.rs2];
                    imm_q <= imm;
                end
                S_EXEC: begin
                    // Jumps redirect PC here, so the link value is kept.
                    alu_q <= (is_jal || is_jalr) ? pc_plus4 : alu_y;
                    if (is_branch) pc <= taken ? br_target : pc_plus4;
                    if (is_jal)    pc <= br_target;
                    if (is_jalr)   pc <= {alu_y[31:1], 1'b0};
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_load) mdr <= mem_rdata;
                        pc <= pc_plus4;
                    end
                end
                S_WB: begin
                    if (!(is_load || is_jal || is_jalr)) pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == S_WB && ins.rd != 5'd0) begin
            rf[ins.rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: ISA-level model, wait-state memory,
// directed programs with hand-computed expectations.
module tb_multicycle_datapath;
    import multicycle_pkg::*;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] PC_RST = 32'h40;
    localparam logic [31:0] EBRK   = 32'h00100073;

    logic              clk;
    logic              rst_n;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              halted;
    logic              retire;
    logic [31:0]       pc_dbg;
    logic [2:0]        state_dbg;

    multicycle_datapath #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RST)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .retire    (retire),
        .pc_dbg    (pc_dbg),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- memory with per-address wait states
    logic [31:0] mem [64];
    logic [31:0] img [64];
    logic        load_req;
    int          phase;
    int          cnt;

    function automatic int wait_of(input int ph, input logic [7:0] a);
        if (ph == 0) return (a == 8'h4C || a == 8'h50 || a == 8'h10) ? 2 : 0;
        if (ph == 2) return (a == 8'h10) ? 5 : 0;
        return 0;
    endfunction

    assign mem_ready = mem_req && (cnt == wait_of(phase, mem_addr));
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
            cnt <= 0;
        end else if (mem_req && mem_ready) begin
            cnt <= 0;
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    // ---------------- instruction encoders
    function automatic logic [31:0] i_t(input int imm, input int rs1,
        input int f3, input int rd, input logic [6:0] opc);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2,
        input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2,
        input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2,
        input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
                v[4:1], v[11], 7'h63};
    endfunction

    // ---------------- ISA-level reference model
    logic [31:0] mr [32];
    logic [31:0] mmem [64];
    logic [31:0] mpc;
    logic        p_wr;
    logic        p_st;
    logic [4:0]  p_rd;
    logic [5:0]  p_word;

    function automatic logic [31:0] alu_model(input logic [2:0] f3,
        input logic alt, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0])
                                : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mr[i] = '0;
        for (int i = 0; i < 64; i++) mmem[i] = img[i];
        mpc = PC_RST;
    endtask

    task automatic model_step(output int base, output int nw);
        logic [31:0] ins, a, b, b2, res, npc, da;
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        logic        wr, tk, alt;
        ins  = mmem[mpc[7:2]];
        a    = mr[ins[19:15]];
        b    = mr[ins[24:20]];
        im_i = {{20{ins[31]}}, ins[31:20]};
        im_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        im_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                ins[11:8], 1'b0};
        im_u = {ins[31:12], 12'h0};
        im_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                ins[30:21], 1'b0};
        npc  = mpc + 4;
        res  = '0;
        wr   = 1'b0;
        tk   = 1'b0;
        p_st = 1'b0;
        base = 4;
        nw   = wait_of(phase, {mpc[7:2], 2'b00});
        case (ins[6:0])
            7'h13, 7'h33: begin
                b2  = ins[5] ? b : im_i;
                alt = ins[30] && (ins[5] || ins[14:12] == 3'd5);
                res = alu_model(ins[14:12], alt, a, b2);
                wr  = 1'b1;
            end
            7'h03: begin
                da   = a + im_i;
                res  = mmem[da[7:2]];
                wr   = 1'b1;
                base = 5;
                nw  += wait_of(phase, {da[7:2], 2'b00});
            end
            7'h23: begin
                da     = a + im_s;
                mmem[da[7:2]] = b;
                p_st   = 1'b1;
                p_word = da[7:2];
                nw    += wait_of(phase, {da[7:2], 2'b00});
            end
            7'h63: begin
                case (ins[14:12])
                    3'd0: tk = a == b;
                    3'd1: tk = a != b;
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    3'd7: tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) npc = mpc + im_b;
                base = 3;
            end
            7'h6F: begin res = mpc + 4; npc = mpc + im_j; wr = 1'b1; end
            7'h67: begin
                res = mpc + 4;
                npc = (a + im_i) & ~32'h1;
                wr  = 1'b1;
            end
            7'h37: begin res = im_u; wr = 1'b1; end
            7'h17: begin res = mpc + im_u; wr = 1'b1; end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) mr[ins[11:7]] = res;
        p_wr = wr;
        p_rd = ins[11:7];
        mpc  = npc;
    endtask

    // ---------------- per-cycle compare process
    logic        chk_en;
    logic        busy, pend, prev_wait, prev_we;
    logic [7:0]  prev_addr;
    logic [31:0] prev_wdata;
    int          cyc, start, nret, lat, eb, ew;
    int          lat_hist [16];
    int          rt_hist [16];
    logic [31:0] pc_hist [16];

    always @(negedge clk) begin
        if (!chk_en) begin
            busy      = 1'b0;
            pend      = 1'b0;
            prev_wait = 1'b0;
        end else begin
            cyc++;
            if (pend) begin
                pend = 1'b0;
                chk("pc_after_retire", pc_dbg, mpc);
                if (p_wr) chk("rd_value", dut.rf[p_rd], mr[p_rd]);
                if (p_st) chk("store_word", mem[p_word], mmem[p_word]);
                pc_hist[nret-1] = pc_dbg;
            end
            if (mem_req) begin
                if (prev_wait) begin
                    chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
                    chk("hold_we", 32'(mem_we), 32'(prev_we));
                    chk("hold_wdata", mem_wdata, prev_wdata);
                end
                if (!busy) begin
                    busy  = 1'b1;
                    start = cyc;
                end
            end
            prev_wait  = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (retire) begin
                model_step(eb, ew);
                lat = cyc - start + 1;
                chk("latency", lat, eb + ew);
                lat_hist[nret] = lat;
                rt_hist[nret]  = cyc;
                nret++;
                busy = 1'b0;
                pend = 1'b1;
            end
        end
    end

    // ---------------- stimulus
    task automatic do_reset_phase(input int ph);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        phase  = ph;
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rst_pc", pc_dbg, PC_RST);
        load_req = 1'b1;
        @(posedge clk);
        #2;
        load_req = 1'b0;
        model_reset();
        nret = 0;
        cyc  = 0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("halt_reached", 32'(halted), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        chk_en   = 1'b0;
        load_req = 1'b0;
        phase    = 0;
        cnt      = 0;

        // Phase A: ALU chain, slow SW/LW, BLT taken, BLTU not, EBREAK.
        for (int i = 0; i < 64; i++) img[i] = '0;
        img[4]  = 32'h11111111;
        img[16] = i_t(5, 0, 0, 1, 7'h13);
        img[17] = i_t(-3, 0, 0, 2, 7'h13);
        img[18] = r_t(0, 2, 1, 0, 3);
        img[19] = s_t(16, 3, 0);
        img[20] = i_t(16, 0, 2, 4, 7'h03);
        img[21] = b_t(8, 1, 2, 4);
        img[22] = i_t(1, 0, 0, 6, 7'h13);
        img[23] = b_t(8, 1, 2, 6);
        img[24] = EBRK;
        do_reset_phase(0);
        wait_halt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(mem_req), 0);
            chk("halt_retire", 32'(retire), 0);
            chk("halt_flag", 32'(halted), 1);
        end
        chk("a_x1", dut.rf[1], 32'd5);
        chk("a_x2", dut.rf[2], 32'hFFFF_FFFD);
        chk("a_x3", dut.rf[3], 32'd2);
        chk("a_x4", dut.rf[4], 32'd2);
        chk("a_x6_skipped", dut.rf[6], 32'd0);
        chk("a_mem4", mem[4], 32'd2);
        chk("a_retires", nret, 7);
        chk("a_gap1", rt_hist[1] - rt_hist[0], 4);
        chk("a_gap2", rt_hist[2] - rt_hist[1], 4);
        chk("a_sw_lat", lat_hist[3], 8);
        chk("a_lw_lat", lat_hist[4], 9);
        chk("a_blt_pc", pc_hist[5], 32'h5C);
        chk("a_blt_lat", lat_hist[5], 3);
        chk("a_bltu_pc", pc_hist[6], 32'h60);
        chk("a_halt_pc", pc_dbg, 32'h60);

        // Phase B: JALR to an odd target, then a write to x0.
        for (int i = 0; i < 64; i++) img[i] = '0;
        img[16] = i_t(32'h13, 0, 0, 1, 7'h13);
        img[17] = i_t(0, 1, 0, 5, 7'h67);
        img[4]  = i_t(7, 0, 0, 0, 7'h13);
        img[5]  = EBRK;
        do_reset_phase(1);
        wait_halt();
        chk("b_retires", nret, 3);
        chk("b_jalr_pc", pc_hist[1], 32'h12);
        chk("b_x5_link", dut.rf[5], 32'h48);
        chk("b_x0", dut.rf[0], 32'd0);
        chk("b_x1", dut.rf[1], 32'h13);
        chk("b_final_pc", pc_dbg, 32'h16);

        // Phase C: reset lands in the middle of a slow SW.
        for (int i = 0; i < 64; i++) img[i] = '0;
        img[4]  = 32'hDEAD_BEEF;
        img[16] = i_t(9, 0, 0, 1, 7'h13);
        img[17] = s_t(16, 1, 0);
        do_reset_phase(2);
        n = 0;
        while (!(mem_req && mem_we) && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("c_sw_req_seen", 32'(mem_req && mem_we), 1);
        @(posedge clk);
        #2;
        chk("c_still_waiting", 32'(mem_req && !mem_ready), 1);
        rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("c_req_dropped", 32'(mem_req), 0);
        chk("c_we_dropped", 32'(mem_we), 0);
        chk("c_retire", 32'(retire), 0);
        chk("c_halted", 32'(halted), 0);
        chk("c_pc", pc_dbg, PC_RST);
        chk("c_state", 32'(state_dbg), 32'(S_IDLE));
        chk("c_x1_cleared", dut.rf[1], 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("c_mem_kept", mem[4], 32'hDEAD_BEEF);
        model_reset();
        nret   = 0;
        cyc    = 0;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("c_req_before_edge1", 32'(mem_req), 0);
        @(posedge clk);
        #1;
        chk("c_req_after_edge1", 32'(mem_req), 1);
        chk("c_first_addr", 32'(mem_addr), 32'h40);
        wait_halt();
        chk("c_retires", nret, 2);
        chk("c_sw_lat", lat_hist[1], 9);
        chk("c_mem_written", mem[4], 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
